// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, reset vector and the
// fetch-to-decode bundle carried through the prefetch FIFO.
package proc_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam logic [WORD_SIZE-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [WORD_SIZE-1:0] inst;
        logic [WORD_SIZE-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_sync_fifo.sv
// Small synchronous FIFO with flush; pointers wrap at DEPTH (power of two).
// Overflow is never expected: the producer is credit-limited.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; the reader masks it while empty.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush)
            mem[wr_ptr] <= wdata;
    end

    always @(posedge clk) begin
        if (!rst && !flush && push && !do_pop)
            assert (!full) else $error("sync_fifo overflow");
    end

endmodule

// File: rtl/inst_fetch_stage.sv
// Fetch stage: owns the PC, issues to a 1-cycle instruction memory and
// hands {inst, pc} to decode through a credit-limited prefetch FIFO.
module inst_fetch_stage #(
    parameter int WORD_SIZE = proc_pkg::WORD_SIZE,
    parameter int FIFO_DEPTH = proc_pkg::FIFO_DEPTH,
    parameter logic [WORD_SIZE-1:0] RESET_PC = proc_pkg::RESET_PC
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [WORD_SIZE-1:0] InstIn,
    output logic [WORD_SIZE-1:0] InstAddr,
    input  logic                 Redirect,
    input  logic [WORD_SIZE-1:0] RedirectAddr,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [WORD_SIZE-1:0] OutInst,
    output logic [WORD_SIZE-1:0] OutPC
);

    import proc_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0] CAP = (AW+2)'(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] inflight_pc;
    logic                 inflight_valid;
    logic [AW:0]          count;
    logic [AW+1:0]        occupancy;
    logic                 full;
    logic                 empty;
    logic                 issue;
    logic                 push;
    logic                 pop;
    fetch_entry_t         wr_entry;
    fetch_entry_t         rd_entry;

    // Reserve a slot for the word in flight so a return always fits.
    assign occupancy = {1'b0, count} + (AW+2)'(inflight_valid);
    assign issue     = Enable & ~Redirect & (occupancy < CAP);
    assign push      = inflight_valid & ~Redirect;
    assign OutValid  = ~empty & Enable & ~Redirect;
    assign pop       = OutValid & OutReady;

    assign wr_entry.inst = InstIn;
    assign wr_entry.pc   = inflight_pc;

    assign InstAddr = pc;
    assign OutInst  = empty ? '0 : rd_entry.inst;
    assign OutPC    = empty ? '0 : rd_entry.pc;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc             <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
        end else if (Redirect) begin
            pc             <= RedirectAddr;
            inflight_valid <= 1'b0;
        end else begin
            inflight_valid <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clock),
        .rst   (Reset),
        .push  (push),
        .pop   (pop),
        .flush (Redirect),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule
